// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the radix-4 Booth recoding logic. This package is
// used by the sequential digit encoder and by the parallel multiplier.
//   SEL_*              select codes {neg,one,two} that drive the
//                      partial-product mux
//   state_t            FSM states of the sequential encoder
//   booth_triplet_enc  maps {b[2i+1], b[2i], b[2i-1]} to a select code
// ---------------------------------------------------------------------------
package booth_pkg;

    localparam logic [2:0] SEL_ZERO = 3'b000;
    localparam logic [2:0] SEL_P1   = 3'b010;
    localparam logic [2:0] SEL_P2   = 3'b001;
    localparam logic [2:0] SEL_M1   = 3'b110;
    localparam logic [2:0] SEL_M2   = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Triplets 000 and 111 both mean a zero digit. They map to SEL_ZERO, so
    // the mux never receives a "negative zero" (100).
    function automatic logic [2:0] booth_triplet_enc(input logic [2:0] triplet);
        logic [2:0] sel;
        case (triplet)
            3'b001, 3'b010: sel = SEL_P1;
            3'b011:         sel = SEL_P2;
            3'b100:         sel = SEL_M2;
            3'b101, 3'b110: sel = SEL_M1;
            default:        sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// ---------------------------------------------------------------------------
// booth_digit_enc
// Combinational converter from a radix-4 Booth triplet to a mux select code.
// The parallel multiplier uses this same block.
//   triplet  in   3  {b[2i+1], b[2i], b[2i-1]}
//   sel      out  3  select code {neg,one,two}
// ---------------------------------------------------------------------------
module booth_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0] triplet,
    output logic [2:0] sel
);

    assign sel = booth_triplet_enc(triplet);

endmodule

// File: rtl/booth_r4_digit_encoder.sv
// ---------------------------------------------------------------------------
// booth_r4_digit_encoder
// Sequential radix-4 Booth recoder. It accepts one signed multiplier operand
// and emits one select code per digit, starting with the least significant
// digit. A valid/ready handshake is used on both the input and output sides.
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   flush      in   1      synchronous abort of the current operand
//   in_valid   in   1      operand offered
//   in_ready   out  1      operand can be accepted this cycle
//   in_b       in   WIDTH  signed multiplier operand
//   out_valid  out  1      digit outputs valid
//   out_ready  in   1      downstream takes the current digit
//   out_sel    out  3      Booth select {neg,one,two}
//   out_idx    out  IDXW   digit index (weight 4^idx)
//   out_last   out  1      high on the final digit
// ---------------------------------------------------------------------------
module booth_r4_digit_encoder
    import booth_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int NDIG  = WIDTH / 2,
    localparam int IDXW  = $clog2(NDIG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_sel,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last
);

    state_t          state;
    logic [WIDTH:0]  sr;
    logic [IDXW-1:0] idx;
    logic [2:0]      sel;
    logic            accept;
    logic            take;

    // The low three bits of sr always hold the current triplet. sr is
    // loaded with a zero in bit 0, which supplies b[-1] for digit 0.
    booth_digit_enc u_digit_enc (
        .triplet (sr[2:0]),
        .sel     (sel)
    );

    // All digit outputs depend only on registered state, so no path exists
    // from the in_* inputs to the out_* outputs.
    assign out_valid = (state == ST_RUN);
    assign out_last  = out_valid && (idx == IDXW'(NDIG - 1));
    assign out_sel   = sel;
    assign out_idx   = idx;

    // A new operand can enter while the last digit is being taken. This lets
    // operands run back to back with no bubble. flush blocks acceptance so
    // the aborted cycle cannot start a new operand.
    assign in_ready = !flush && (!out_valid || (out_last && out_ready));
    assign accept   = in_valid && in_ready;
    assign take     = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sr    <= '0;
            idx   <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else if (accept) begin
            state <= ST_RUN;
            sr    <= {in_b, 1'b0};
            idx   <= '0;
        end else if (take) begin
            if (out_last) begin
                state <= ST_IDLE;
            end else begin
                // The arithmetic shift keeps the sign bit, so the upper
                // digits of a negative operand see sign-extended triplets.
                sr  <= {{2{sr[WIDTH]}}, sr[WIDTH:2]};
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_booth_r4_digit_encoder.sv
// ---------------------------------------------------------------------------
// tb_booth_r4_digit_encoder
// Self-checking bench for the sequential radix-4 Booth recoder (WIDTH = 8).
// It runs directed scenarios and then random operands with random
// backpressure. The random run is compared against a digit-value model.
// ---------------------------------------------------------------------------
module tb_booth_r4_digit_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_sel;
    logic [1:0] out_idx;
    logic       out_last;

    int n_checks = 0;
    int n_fail   = 0;

    booth_r4_digit_encoder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 ns after the rising edge. Inputs are changed at
    // the same point, so they are stable well before the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Booth digit value: -2*b[2i+1] + b[2i] + b[2i-1], where b[-1] = 0.
    // The value is then converted to the mux select code.
    function automatic logic [2:0] model_sel(input logic [7:0] b, input int i);
        int lo;
        int d;
        logic [2:0] code;
        lo = (i == 0) ? 0 : int'(b[2*i-1]);
        d  = int'(b[2*i]) + lo - 2 * int'(b[2*i+1]);
        case (d)
            1:       code = 3'b010;
            2:       code = 3'b001;
            -1:      code = 3'b110;
            -2:      code = 3'b101;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    // Converts a select code back to its signed digit value.
    // Codes that must never be emitted return 99.
    function automatic int sel_value(input logic [2:0] s);
        case (s)
            3'b000:  return 0;
            3'b010:  return 1;
            3'b001:  return 2;
            3'b110:  return -1;
            3'b101:  return -2;
            default: return 99;
        endcase
    endfunction

    // Sends one operand with out_ready held high. Each digit is checked
    // against exp[3*i +: 3].
    task automatic run_operand(input logic [7:0] b, input logic [11:0] exp, input string name);
        int k;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_b      = b;
        #1;
        k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL %s accept_timeout in_ready=%b required 1", name, in_ready);
        end
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== exp[3*i +: 3] || out_idx !== 2'(i)
                || out_last !== (i == 3)) begin
                n_fail++;
                $display("[TB] FAIL %s digit%0d valid=%b sel=%b idx=%0d last=%b required 1 %b %0d %b",
                         name, i, out_valid, out_sel, out_idx, out_last, exp[3*i +: 3], i, (i == 3));
            end
            step();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s idle_after valid=%b required 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_sel !== 3'b000 || out_idx !== 2'd0 || out_last !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs valid=%b sel=%b idx=%0d last=%b required 0 000 0 0",
                     out_valid, out_sel, out_idx, out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_in_ready in_ready=%b required 1", in_ready);
        end
        step();
    endtask

    task automatic test_directed();
        run_operand(8'h07, {3'b000, 3'b000, 3'b001, 3'b110}, "op_07");
        run_operand(8'h80, {3'b101, 3'b000, 3'b000, 3'b000}, "op_80");
        run_operand(8'hFF, {3'b000, 3'b000, 3'b000, 3'b110}, "op_FF");
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_b      = 8'h55;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'b010 || out_idx !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL stall_digit0 valid=%b sel=%b idx=%0d required 1 010 0",
                     out_valid, out_sel, out_idx);
        end
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 3'b010 || out_idx !== 2'd1 || out_last !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL stall_hold%0d valid=%b sel=%b idx=%0d last=%b required 1 010 1 0",
                         c, out_valid, out_sel, out_idx, out_last);
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 3'b010 || out_idx !== 2'(i) || out_last !== (i == 3)) begin
                n_fail++;
                $display("[TB] FAIL stall_resume%0d valid=%b sel=%b idx=%0d last=%b required 1 010 %0d %b",
                         i, out_valid, out_sel, out_idx, out_last, i, (i == 3));
            end
            step();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stall_idle valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_a;
        logic [11:0] exp_b;
        exp_a = {3'b000, 3'b000, 3'b001, 3'b110};
        exp_b = {3'b101, 3'b000, 3'b000, 3'b000};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_b      = 8'h07;
        step();
        in_b = 8'h80;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] e;
            e = (i < 4) ? exp_a[3*(i%4) +: 3] : exp_b[3*(i%4) +: 3];
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== e || out_idx !== 2'(i % 4)
                || in_ready !== ((i % 4) == 3)) begin
                n_fail++;
                $display("[TB] FAIL b2b_cycle%0d valid=%b sel=%b idx=%0d in_ready=%b required 1 %b %0d %b",
                         i, out_valid, out_sel, out_idx, in_ready, e, i % 4, ((i % 4) == 3));
            end
            step();
            if (i == 3) in_valid = 1'b0;
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_idle valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_b      = 8'h07;
        step();
        in_valid = 1'b0;
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL flush_pre valid=%b idx=%0d required 1 2", out_valid, out_idx);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_b     = 8'hFF;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_in_ready in_ready=%b required 0", in_ready);
        end
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL flush_after valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        run_operand(8'h55, {3'b010, 3'b010, 3'b010, 3'b010}, "post_flush");
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_b      = 8'h07;
        step();
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_idx !== 2'd1 || out_sel !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL areset_pre idx=%0d sel=%b required 1 001", out_idx, out_sel);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_sel !== 3'b000 || out_idx !== 2'd0 || out_last !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL areset_outputs valid=%b sel=%b idx=%0d last=%b required 0 000 0 0",
                     out_valid, out_sel, out_idx, out_last);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        run_operand(8'hFF, {3'b000, 3'b000, 3'b000, 3'b110}, "post_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int cnt;
            int cycles;
            int sum;
            b         = 8'($urandom);
            in_b      = b;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            cycles = 0;
            while (!in_ready && cycles < 20) begin
                step();
                cycles++;
            end
            step();
            in_valid = 1'b0;
            cnt    = 0;
            cycles = 0;
            sum    = 0;
            while (cnt < 4 && cycles < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                if (out_valid && out_ready) begin
                    n_checks++;
                    if (out_sel !== model_sel(b, cnt) || out_idx !== 2'(cnt) || out_last !== (cnt == 3)
                        || sel_value(out_sel) == 99) begin
                        n_fail++;
                        $display("[TB] FAIL rand_digit b=%h d%0d sel=%b idx=%0d last=%b required %b %0d %b",
                                 b, cnt, out_sel, out_idx, out_last, model_sel(b, cnt), cnt, (cnt == 3));
                    end
                    sum += sel_value(out_sel) * (4 ** cnt);
                    cnt++;
                end
                step();
                cycles++;
            end
            out_ready = 1'b1;
            n_checks++;
            if (cnt != 4 || sum != int'($signed(b))) begin
                n_fail++;
                $display("[TB] FAIL rand_sum b=%h digits=%0d sum=%0d required 4 %0d",
                         b, cnt, sum, int'($signed(b)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
